// File: rtl/sync_debounce_edge_pkg.sv
// Shared constants and helpers for the input conditioner.
// Imported by the per-channel debouncer and the top-level wrapper.
package sync_debounce_edge_pkg;

    localparam int unsigned MIN_STAGES = 2;
    localparam int unsigned MIN_STABLE = 1;
    localparam int unsigned MIN_WIDTH  = 1;

    // Width of a counter that must reach stable-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned stable);
        return (stable < 2) ? 1 : $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_edge_debounce_channel.sv
// One channel: synchronizer chain, optional debounce counter,
// accepted level and registered rise/fall pulses.
module debounce_channel #(
    parameter int unsigned STAGES        = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          DEBOUNCE_EN   = 1'b1,
    parameter logic        RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    import sync_debounce_edge_pkg::*;

    logic [STAGES-1:0] r_sync;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;
    logic              w_s_q;
    logic              w_next;

    assign w_s_q = r_sync[STAGES-1];

    // Plain flop chain, nothing between stages, for metastability settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
        end
    end

    if (DEBOUNCE_EN) begin : g_deb
        localparam int unsigned CW = cnt_width(STABLE_CYCLES);
        localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

        logic [CW-1:0] r_cnt;

        // Count consecutive cycles the synced input disagrees with the level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_s_q == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end

        assign w_next = ((w_s_q != r_level) && (r_cnt == LAST))
                      ? w_s_q : r_level;
    end else begin : g_byp
        assign w_next = w_s_q;
    end

    // Level and edge pulses update together so a pulse marks the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= RESET_VALUE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= w_next;
            r_rise  <= ~r_level & w_next;
            r_fall  <= r_level & ~w_next;
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule

// File: rtl/sync_debounce_edge.sv
// Input conditioner top: WIDTH independent debounce channels.
// Only wiring and parameter sanity checks live here.
module sync_debounce_edge #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned STAGES        = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          DEBOUNCE_EN   = 1'b1,
    parameter logic        RESET_VALUE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    import sync_debounce_edge_pkg::*;

    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("sync_debounce_edge: STAGES must be >= 2");
    end

    if (STABLE_CYCLES < MIN_STABLE) begin : g_bad_stable
        $error("sync_debounce_edge: STABLE_CYCLES must be >= 1");
    end

    if (WIDTH < MIN_WIDTH) begin : g_bad_width
        $error("sync_debounce_edge: WIDTH must be >= 1");
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .STAGES        (STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .DEBOUNCE_EN   (DEBOUNCE_EN),
            .RESET_VALUE   (RESET_VALUE)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .async_in   (async_in[g]),
            .level_out  (level_out[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g])
        );
    end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Scoreboard bench: three DUT configurations fed the same random stream,
// checked against a window-based reference model of the debounce rules.
module tb_sync_debounce_edge;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] async_in;
    logic       c_in;

    logic [3:0] a_lvl, a_rise, a_fall;
    logic [3:0] b_lvl, b_rise, b_fall;
    logic       c_lvl, c_rise, c_fall;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // model state: edges since reset and inputs sampled at each edge
    int         e = 0;
    logic [3:0] hist[$];
    logic [3:0] lvl_a, lvl_b, lvl_c;

    sync_debounce_edge #(
        .WIDTH(4), .STAGES(2), .STABLE_CYCLES(4),
        .DEBOUNCE_EN(1'b1), .RESET_VALUE(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .async_in(async_in),
        .level_out(a_lvl), .rise_pulse(a_rise), .fall_pulse(a_fall)
    );

    sync_debounce_edge #(
        .WIDTH(4), .STAGES(3), .STABLE_CYCLES(4),
        .DEBOUNCE_EN(1'b0), .RESET_VALUE(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .async_in(async_in),
        .level_out(b_lvl), .rise_pulse(b_rise), .fall_pulse(b_fall)
    );

    sync_debounce_edge #(
        .WIDTH(1), .STAGES(3), .STABLE_CYCLES(1),
        .DEBOUNCE_EN(1'b1), .RESET_VALUE(1'b1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .async_in(c_in),
        .level_out(c_lvl), .rise_pulse(c_rise), .fall_pulse(c_fall)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // synced value seen just before edge t: input sampled at edge t-s
    function automatic logic sq_pre(input int t, input int s,
                                    input logic rv, input int b);
        int idx;
        idx = t - s;
        if (idx < 1) return rv;
        return hist[idx-1][b];
    endfunction

    // A new level is accepted at edge e when the last n pre-edge synced
    // values all disagree with the current level; bypass just follows.
    function automatic exp_t model(input int s, input int n, input bit en,
                                   input logic rv, input int w,
                                   inout logic [3:0] lvl);
        exp_t       ex;
        logic [3:0] nl;
        bit         flip;
        ex = '0;
        nl = lvl;
        for (int b = 0; b < w; b++) begin
            if (en) begin
                flip = 1'b1;
                for (int t = e - n + 1; t <= e; t++)
                    if (sq_pre(t, s, rv, b) == lvl[b]) flip = 1'b0;
                if (flip) nl[b] = ~lvl[b];
            end else begin
                nl[b] = sq_pre(e, s, rv, b);
            end
            ex.rise[b] = ~lvl[b] & nl[b];
            ex.fall[b] = lvl[b] & ~nl[b];
        end
        ex.lvl = nl;
        lvl = nl;
        return ex;
    endfunction

    task automatic step(input logic [3:0] v, input bit rst);
        exp_t ea, eb, ec;
        @(negedge clk);
        rst_n    = !rst;
        async_in = v;
        c_in     = v[0];
        if (rst) begin
            e = 0;
            hist.delete();
            lvl_a = 4'b0000;
            lvl_b = 4'b0000;
            lvl_c = 4'b0001;
            ea = '0;
            eb = '0;
            ec = '0;
            ec.lvl = 4'b0001;
        end else begin
            e++;
            hist.push_back(v);
            ea = model(2, 4, 1'b1, 1'b0, 4, lvl_a);
            eb = model(3, 4, 1'b0, 1'b0, 4, lvl_b);
            ec = model(3, 1, 1'b1, 1'b1, 1, lvl_c);
        end
        qa.push_back(ea);
        qb.push_back(eb);
        qc.push_back(ec);
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    task automatic cmp(input string nm, input exp_t ex, input exp_t got);
        n_cmp++;
        if (got !== ex) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                     nm, cyc, got.lvl, got.rise, got.fall,
                     ex.lvl, ex.rise, ex.fall);
        end
    endtask

    // monitor: one expected response per DUT per clock edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty cyc=%0d got %0d/%0d/%0d entries want >=1",
                         cyc, qa.size(), qb.size(), qc.size());
            end else begin
                cmp("dut_a", qa.pop_front(), {a_lvl, a_rise, a_fall});
                cmp("dut_b", qb.pop_front(), {b_lvl, b_rise, b_fall});
                cmp("dut_c", qc.pop_front(),
                    {3'b000, c_lvl, 3'b000, c_rise, 3'b000, c_fall});
            end
        end
    end

    initial begin
        logic [3:0] cur;
        rst_n    = 1'b0;
        async_in = 4'b0000;
        c_in     = 1'b0;

        // reset held while inputs toggle
        for (int i = 0; i < 5; i++) step(4'($urandom_range(0, 15)), 1'b1);

        // release with inputs high: no pulse at release, debounced rise later
        hold(4'b1111, 10);
        hold(4'b0000, 10);

        // short glitch then a genuine step
        hold(4'b0001, 3);
        hold(4'b0000, 6);
        hold(4'b0001, 8);
        hold(4'b0000, 8);

        // simultaneous multi-channel changes
        hold(4'b1000, 10);
        hold(4'b0101, 10);

        // single-cycle glitch on bit 1 (bypass shows a rise/fall pair)
        hold(4'b0111, 1);
        hold(4'b0101, 10);

        // reset in the middle of a debounce count
        hold(4'b1010, 4);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b1);
        hold(4'b1010, 12);

        // random phase with occasional resets
        cur = 4'b1010;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    step(4'($urandom_range(0, 15)), 1'b1);
            end else begin
                if ($urandom_range(0, 5) == 0)
                    cur = cur ^ 4'($urandom_range(1, 15));
                step(cur, 1'b0);
            end
        end

        @(posedge clk);
        #3;
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d/%0d/%0d left want 0",
                     qa.size(), qb.size(), qc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
